// File: rtl/hazard_unit.sv
// Hazard detection, forwarding selects and multi-cycle mul/div busy tracker.
// Optional stall counter output enabled by HAZARD_STALL_STATS_EN.
module hazard_unit #(
  parameter logic [4:0]  MUL_CODE   = 5'b01000,
  parameter logic [4:0]  DIV_CODE   = 5'b01001,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MulDivUseD,
  input  logic [4:0] ALUControlE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MDBusy,
  output logic       MDDone
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0] StallCount
`endif
);

  localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int unsigned CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             lwstall, branchstall, mdstall, stall;

  always_comb begin
    ForwardAE = 2'b00;
    if (RsE != '0 && RegWriteM && RsE == WriteRegM)      ForwardAE = 2'b10;
    else if (RsE != '0 && RegWriteW && RsE == WriteRegW) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RtE != '0 && RegWriteM && RtE == WriteRegM)      ForwardBE = 2'b10;
    else if (RtE != '0 && RegWriteW && RtE == WriteRegW) ForwardBE = 2'b01;

    ForwardAD = (RsD != '0) && RegWriteM && (RsD == WriteRegM);
    ForwardBD = (RtD != '0) && RegWriteM && (RtD == WriteRegM);
  end

  always_comb begin
    lwstall     = MemtoRegE && (RtE == RsD || RtE == RtD);
    branchstall = BranchD &&
                  ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                   (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    mdstall     = MDBusy && MulDivUseD;
    stall       = lwstall | branchstall | mdstall;
    StallF      = stall;
    StallD      = stall;
    FlushE      = stall;
  end

  // Start codes are only honoured from IDLE; a busy unit finishes its current op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ALUControlE == MUL_CODE) begin
          state_d = BUSY;
          cnt_d   = CW'(MUL_CYCLES - 1);
        end else if (ALUControlE == DIV_CODE) begin
          state_d = BUSY;
          cnt_d   = CW'(DIV_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign MDBusy = (state_q == BUSY);
  assign MDDone = done_q;

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (default 4-cycle MUL, 32-cycle DIV).
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, MulDivUseD;
  logic [4:0] ALUControlE;
  logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MDBusy, MDDone;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] StallCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .MUL_CODE(5'b01000),
    .DIV_CODE(5'b01001),
    .MUL_CYCLES(4),
    .DIV_CYCLES(32)
  ) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .MulDivUseD(MulDivUseD), .ALUControlE(ALUControlE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MDBusy(MDBusy), .MDDone(MDDone)
`ifdef HAZARD_STALL_STATS_EN
    , .StallCount(StallCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; MulDivUseD = 0;
    ALUControlE = '0;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, "_StallF"}, 32'(StallF), 32'(exp));
    check({tag, "_StallD"}, 32'(StallD), 32'(exp));
    check({tag, "_FlushE"}, 32'(FlushE), 32'(exp));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #23;
    check("rst_MDBusy", 32'(MDBusy), 32'd0);
    check("rst_MDDone", 32'(MDDone), 32'd0);
    check_stall("rst", 1'b0);
    check("rst_FAE", 32'(ForwardAE), 32'd0);

    @(negedge clk);
    reset = 1'b1;

    // Forwarding into Execute
    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    #1 check("fae_M", 32'(ForwardAE), 32'd2);
    RegWriteM = 0;
    #1 check("fae_W", 32'(ForwardAE), 32'd1);
    RsE = 0;
    #1 check("fae_zero", 32'(ForwardAE), 32'd0);
    RtE = 5; RegWriteM = 1;
    #1 check("fbe_M", 32'(ForwardBE), 32'd2);
    WriteRegM = 6;
    #1 check("fbe_W", 32'(ForwardBE), 32'd1);
    RsD = 6;
    #1 check("fad", 32'(ForwardAD), 32'd1);
    check("fbd_no", 32'(ForwardBD), 32'd0);
    clear_inputs();

    // Load-use stall
    MemtoRegE = 1; RtE = 7; RsD = 7; RtD = 3;
    #1 check_stall("lw_hit", 1'b1);
    RsD = 3;
    #1 check_stall("lw_miss", 1'b0);
    clear_inputs();

    // Branch stall then forward from M
    @(negedge clk);
    BranchD = 1; RegWriteE = 1; WriteRegE = 9; RtD = 9; RsD = 2;
    #1 check_stall("br_E", 1'b1);
    @(negedge clk);
    RegWriteE = 0; WriteRegE = 0;
    MemtoRegM = 0; WriteRegM = 9; RegWriteM = 1;
    #1 check_stall("br_M", 1'b0);
    check("br_fbd", 32'(ForwardBD), 32'd1);
    MemtoRegM = 1;
    #1 check_stall("br_ldM", 1'b1);
    clear_inputs();

    // MUL: 4 busy cycles, then one MDDone pulse; DIV code mid-busy is ignored
    @(negedge clk);
    ALUControlE = 5'b01000; MulDivUseD = 1;
    #1 check("mul_pre_busy", 32'(MDBusy), 32'd0);
    check_stall("mul_pre", 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      ALUControlE = (i == 2) ? 5'b01001 : 5'b00000;
      #1 check($sformatf("mul_busy%0d", i), 32'(MDBusy), 32'd1);
      check($sformatf("mul_done%0d", i), 32'(MDDone), 32'd0);
      check_stall($sformatf("mul_st%0d", i), 1'b1);
    end
    @(negedge clk);
    ALUControlE = '0;
    #1 check("mul_end_busy", 32'(MDBusy), 32'd0);
    check("mul_end_done", 32'(MDDone), 32'd1);
    check_stall("mul_end", 1'b0);
    @(negedge clk);
    #1 check("mul_done_off", 32'(MDDone), 32'd0);
    MulDivUseD = 0;

    // DIV then asynchronous reset after 10 busy cycles
    @(negedge clk);
    ALUControlE = 5'b01001;
    @(negedge clk);
    ALUControlE = '0;
    #1 check("div_busy1", 32'(MDBusy), 32'd1);
    repeat (9) @(negedge clk);
    #1 check("div_busy10", 32'(MDBusy), 32'd1);
    MulDivUseD = 1;
    #1 check_stall("div_mdstall", 1'b1);
    #1 reset = 1'b0;
    #1 check("areset_busy", 32'(MDBusy), 32'd0);
    check("areset_done", 32'(MDDone), 32'd0);
    check_stall("areset", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("post_rst_busy", 32'(MDBusy), 32'd0);
    check("post_rst_done", 32'(MDDone), 32'd0);
    MulDivUseD = 0;

    // Start sampled on the first edge after reset release
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; ALUControlE = 5'b01000;
    @(negedge clk);
    ALUControlE = '0;
    #1 check("rel_start_busy", 32'(MDBusy), 32'd1);
    repeat (4) @(negedge clk);
    #1 check("rel_start_done", 32'(MDDone), 32'd1);

`ifdef HAZARD_STALL_STATS_EN
    reset = 1'b0;
    #1 check("cnt_rst", StallCount, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    MemtoRegE = 1; RtE = 4; RsD = 4;
    repeat (3) @(negedge clk);
    clear_inputs();
    ALUControlE = 5'b01000;
    @(negedge clk);
    ALUControlE = '0; MulDivUseD = 1;
    repeat (5) @(negedge clk);
    MulDivUseD = 0;
    #1 check("cnt_seven", StallCount, 32'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
